// File: rtl/tcspc_histogram_mem.sv
// Photon-arrival histogram memory: 2-stage read-modify-write increment pipeline,
// hardware clear sweep and handshaked serial readout. Define HIST_SATURATE_EN for saturating bins.
module tcspc_histogram_mem #(
    parameter int unsigned NUM_BINS   = 256,
    parameter int unsigned BIN_ADDR_W = 8,
    parameter int unsigned COUNT_W    = 16,
    parameter int unsigned DROP_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_valid,
    input  logic [BIN_ADDR_W-1:0] inc_bin,
    output logic                  inc_ready,
    input  logic                  clear_req,
    input  logic                  rd_start,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [BIN_ADDR_W-1:0] rd_bin,
    output logic [COUNT_W-1:0]    rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic [DROP_W-1:0]     dropped
);
    localparam logic [1:0] S_CLEAR   = 2'd0;
    localparam logic [1:0] S_ACCUM   = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_READOUT = 2'd3;

    localparam logic [BIN_ADDR_W-1:0] LAST_BIN = BIN_ADDR_W'(NUM_BINS - 1);

    logic [COUNT_W-1:0] mem [NUM_BINS];

    logic [1:0]            state, state_d;
    logic                  pend_clear, pend_clear_d;
    logic [BIN_ADDR_W-1:0] clr_idx, clr_idx_d;
    logic                  rd_valid_d, rd_last_d;
    logic [BIN_ADDR_W-1:0] rd_bin_d, rd_bin_inc;
    logic [COUNT_W-1:0]    rd_data_d;

    logic                  accept;
    logic                  s1_valid, s2_valid;
    logic [BIN_ADDR_W-1:0] s1_bin, s2_bin;
    logic [COUNT_W-1:0]    s2_cnt, s2_next;

    assign accept     = inc_valid && inc_ready;
    assign rd_bin_inc = rd_bin + BIN_ADDR_W'(1);

`ifdef HIST_SATURATE_EN
    assign s2_next = (s2_cnt == '1) ? s2_cnt : s2_cnt + COUNT_W'(1);
`else
    assign s2_next = s2_cnt + COUNT_W'(1);
`endif

    // Stage 1 holds the accepted bin; stage 2 holds the current count, forwarded from
    // the write in flight when the same bin arrives on consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_bin   <= '0;
            s2_valid <= 1'b0;
            s2_bin   <= '0;
            s2_cnt   <= '0;
        end else begin
            s1_valid <= accept;
            s1_bin   <= inc_bin;
            s2_valid <= s1_valid;
            s2_bin   <= s1_bin;
            s2_cnt   <= (s2_valid && s2_bin == s1_bin) ? s2_next : mem[s1_bin];
        end
    end

    // Single write port shared by the clear sweep and the increment pipeline.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (s2_valid) begin
            mem[s2_bin] <= s2_next;
        end
    end

    always_comb begin
        state_d      = state;
        pend_clear_d = pend_clear;
        clr_idx_d    = clr_idx;
        rd_valid_d   = rd_valid;
        rd_bin_d     = rd_bin;
        rd_data_d    = rd_data;
        rd_last_d    = rd_last;
        case (state)
            S_CLEAR: begin
                clr_idx_d = clr_idx + BIN_ADDR_W'(1);
                if (clr_idx == LAST_BIN) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (clear_req) begin
                    state_d      = S_DRAIN;
                    pend_clear_d = 1'b1;
                end else if (rd_start) begin
                    state_d      = S_DRAIN;
                    pend_clear_d = 1'b0;
                end
            end
            S_DRAIN: begin
                // Stage 2 retires on this edge, so only stage 1 must be empty to leave.
                if (!s1_valid) begin
                    if (pend_clear) begin
                        state_d   = S_CLEAR;
                        clr_idx_d = '0;
                    end else begin
                        state_d    = S_READOUT;
                        rd_valid_d = 1'b1;
                        rd_bin_d   = '0;
                        rd_data_d  = (s2_valid && s2_bin == '0) ? s2_next : mem[0];
                        rd_last_d  = 1'b0;
                    end
                end
            end
            S_READOUT: begin
                if (clear_req) begin
                    state_d    = S_CLEAR;
                    clr_idx_d  = '0;
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                end else if (rd_valid && rd_ready) begin
                    if (rd_last) begin
                        state_d    = S_ACCUM;
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                    end else begin
                        rd_bin_d  = rd_bin_inc;
                        rd_data_d = mem[rd_bin_inc];
                        rd_last_d = (rd_bin_inc == LAST_BIN);
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_CLEAR;
            pend_clear <= 1'b0;
            clr_idx    <= '0;
            inc_ready  <= 1'b0;
            rd_valid   <= 1'b0;
            rd_bin     <= '0;
            rd_data    <= '0;
            rd_last    <= 1'b0;
            busy       <= 1'b1;
        end else begin
            state      <= state_d;
            pend_clear <= pend_clear_d;
            clr_idx    <= clr_idx_d;
            inc_ready  <= (state_d == S_ACCUM);
            rd_valid   <= rd_valid_d;
            rd_bin     <= rd_bin_d;
            rd_data    <= rd_data_d;
            rd_last    <= rd_last_d;
            busy       <= (state_d != S_ACCUM) || accept || s1_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropped <= '0;
        end else if (inc_valid && !inc_ready && dropped != '1) begin
            dropped <= dropped + DROP_W'(1);
        end
    end
endmodule

// File: tb/tb_tcspc_histogram_mem.sv
// Bench for tcspc_histogram_mem: a 256x16 instance against an event-count model,
// plus a 4-bin 4-bit instance for count wrap/saturation and dropped-counter saturation.
module tb_tcspc_histogram_mem;
    localparam int unsigned NB  = 256;
    localparam int unsigned AW  = 8;
    localparam int unsigned CW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned SNB = 4;
    localparam int unsigned SAW = 2;
    localparam int unsigned SCW = 4;
    localparam int unsigned SDW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          inc_valid, inc_ready, clear_req, rd_start, rd_valid, rd_ready, rd_last, busy;
    logic [AW-1:0] inc_bin, rd_bin;
    logic [CW-1:0] rd_data;
    logic [DW-1:0] dropped;

    logic           s_inc_valid, s_inc_ready, s_clear_req, s_rd_start, s_rd_valid, s_rd_ready;
    logic           s_rd_last, s_busy;
    logic [SAW-1:0] s_inc_bin, s_rd_bin;
    logic [SCW-1:0] s_rd_data;
    logic [SDW-1:0] s_dropped;

    tcspc_histogram_mem #(.NUM_BINS(NB), .BIN_ADDR_W(AW), .COUNT_W(CW), .DROP_W(DW)) dut (
        .clk(clk), .rst(rst), .inc_valid(inc_valid), .inc_bin(inc_bin), .inc_ready(inc_ready),
        .clear_req(clear_req), .rd_start(rd_start), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_bin(rd_bin), .rd_data(rd_data), .rd_last(rd_last), .busy(busy), .dropped(dropped)
    );

    tcspc_histogram_mem #(.NUM_BINS(SNB), .BIN_ADDR_W(SAW), .COUNT_W(SCW), .DROP_W(SDW)) sdut (
        .clk(clk), .rst(rst), .inc_valid(s_inc_valid), .inc_bin(s_inc_bin), .inc_ready(s_inc_ready),
        .clear_req(s_clear_req), .rd_start(s_rd_start), .rd_valid(s_rd_valid), .rd_ready(s_rd_ready),
        .rd_bin(s_rd_bin), .rd_data(s_rd_data), .rd_last(s_rd_last), .busy(s_busy), .dropped(s_dropped)
    );

    int tests = 0;
    int fails = 0;
    int cnt [NB];    // raw accepted events per bin since the last clear
    int scnt [SNB];
    int drops = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Stored value after n increments of a w-bit bin.
    function automatic int exp_cnt(input int n, input int w);
        int lim = (1 << w) - 1;
`ifdef HIST_SATURATE_EN
        return (n > lim) ? lim : n;
`else
        return n % (1 << w);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int bin);
        inc_valid = 1'b1;
        inc_bin   = AW'(bin);
        tick();
        inc_valid = 1'b0;
        cnt[bin]++;
    endtask

    task automatic clear_model();
        foreach (cnt[i]) cnt[i] = 0;
    endtask

    task automatic wait_accum(input string tag, input int limit);
        int n = 0;
        bit seen_rd = 1'b0;
        while (!inc_ready && n < limit) begin
            if (rd_valid) seen_rd = 1'b1;
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(inc_ready), 1);
        check({tag, "_no_rd"}, 32'(seen_rd), 0);
    endtask

    // Full readout from ACCUM; optional event alongside rd_start and drops during the stream.
    task automatic readout(input string tag, input int stall_pct, input int n_drop, input int ev_bin);
        int idx = 0;
        int cyc = 0;
        int nd = 0;
        bit stalled = 1'b0;
        logic [AW-1:0] pbin = '0;
        logic [CW-1:0] pdata = '0;
        rd_start = 1'b1;
        if (ev_bin >= 0) begin
            inc_valid = 1'b1;
            inc_bin   = AW'(ev_bin);
            cnt[ev_bin]++;
        end
        tick();
        rd_start  = 1'b0;
        inc_valid = 1'b0;
        while (idx < int'(NB) && cyc < 20 * int'(NB)) begin
            inc_valid = 1'b0;
            if (rd_valid) begin
                if (stalled) begin
                    check({tag, "_stall_bin"}, 32'(rd_bin), 32'(pbin));
                    check({tag, "_stall_data"}, 32'(rd_data), 32'(pdata));
                end
                if (nd < n_drop) begin
                    inc_valid = 1'b1;
                    inc_bin   = AW'($urandom_range(0, NB - 1));
                    nd++;
                    drops++;
                end
                rd_ready = (int'($urandom_range(0, 99)) >= stall_pct);
                if (rd_ready) begin
                    check({tag, "_bin"}, 32'(rd_bin), idx);
                    check({tag, "_data"}, 32'(rd_data), exp_cnt(cnt[idx], CW));
                    check({tag, "_last"}, 32'(rd_last), (idx == int'(NB) - 1) ? 1 : 0);
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pbin    = rd_bin;
                    pdata   = rd_data;
                end
            end else begin
                rd_ready = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end
        rd_ready  = 1'b0;
        inc_valid = 1'b0;
        check({tag, "_words"}, idx, NB);
        check({tag, "_end_valid"}, 32'(rd_valid), 0);
        check({tag, "_end_ready"}, 32'(inc_ready), 1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        inc_valid = 1'b0; inc_bin = '0; clear_req = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
        s_inc_valid = 1'b0; s_inc_bin = '0; s_clear_req = 1'b0; s_rd_start = 1'b0; s_rd_ready = 1'b0;
        clear_model();
        foreach (scnt[i]) scnt[i] = 0;
        repeat (3) tick();
        check("rst_inc_ready", 32'(inc_ready), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_last", 32'(rd_last), 0);
        check("rst_rd_bin", 32'(rd_bin), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_dropped", 32'(dropped), 0);

        // Clear sweep lasts exactly NUM_BINS cycles after release.
        rst = 1'b0;
        repeat (NB - 1) tick();
        check("sweep_not_done", 32'(inc_ready), 0);
        check("sweep_busy", 32'(busy), 1);
        tick();
        check("sweep_done_ready", 32'(inc_ready), 1);
        check("sweep_done_busy", 32'(busy), 0);
        tick();
        readout("zero", 0, 0, -1);

        // Same-bin bursts: back-to-back and one-apart.
        repeat (10) push(5);
        push(5); tick(); push(6); tick(); push(5);
        readout("b5b6", 0, 0, -1);

        // Random events clustered on few bins, then an event to bin 0 with rd_start.
        repeat (300) begin
            if ($urandom_range(0, 3) != 0) push(int'($urandom_range(0, 7)));
            else if ($urandom_range(0, 1) != 0) push(int'($urandom_range(0, NB - 1)));
            else tick();
        end
        push(0);
        readout("rand", 50, 0, 0);

        // clear_req beats a simultaneous rd_start; events during the sweep are dropped.
        clear_req = 1'b1; rd_start = 1'b1;
        tick();
        clear_req = 1'b0; rd_start = 1'b0;
        clear_model();
        repeat (2) tick();
        repeat (20) begin
            inc_valid = 1'b1;
            inc_bin   = AW'($urandom_range(0, NB - 1));
            tick();
            drops++;
        end
        inc_valid = 1'b0;
        wait_accum("clr_both", 400);
        check("dropped20", 32'(dropped), drops);
        readout("drop3", 30, 3, -1);
        check("dropped23", 32'(dropped), drops);

        repeat (20) push(int'($urandom_range(0, NB - 1)));
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        clear_model();
        wait_accum("clr2", 400);
        readout("after_clr", 0, 0, -1);
        check("dropped_kept", 32'(dropped), drops);

        // clear_req aborts a readout in progress.
        repeat (15) push(int'($urandom_range(30, 60)));
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        rd_ready = 1'b1;
        n = 0;
        while (!(rd_valid && rd_bin == AW'(40)) && n < 200) begin tick(); n++; end
        check("abort_at40", 32'(rd_bin), 40);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        rd_ready  = 1'b0;
        clear_model();
        check("abort_valid", 32'(rd_valid), 0);
        wait_accum("abort", 400);
        readout("after_abort", 0, 0, -1);

        // Small instance: 17 events to a 4-bit bin, 3 one-apart events, dropped saturation.
        s_inc_valid = 1'b1;
        s_inc_bin   = '0;
        repeat (17) begin tick(); scnt[0]++; end
        s_inc_bin = SAW'(2);
        repeat (3) begin
            s_inc_valid = 1'b1; tick(); scnt[2]++;
            s_inc_valid = 1'b0; tick();
        end
        s_rd_start = 1'b1;
        tick();
        s_rd_start = 1'b0;
        n = 0;
        while (!s_rd_valid && n < 20) begin tick(); n++; end
        check("s_rd_valid", 32'(s_rd_valid), 1);
        s_inc_valid = 1'b1;
        repeat (20) tick();
        s_inc_valid = 1'b0;
        check("s_dropped_sat", 32'(s_dropped), 15);
        s_rd_ready = 1'b1;
        for (int i = 0; i < int'(SNB); i++) begin
            check("s_word_valid", 32'(s_rd_valid), 1);
            check("s_word_bin", 32'(s_rd_bin), i);
            check("s_word_data", 32'(s_rd_data), exp_cnt(scnt[i], SCW));
            check("s_word_last", 32'(s_rd_last), (i == int'(SNB) - 1) ? 1 : 0);
            tick();
        end
        s_rd_ready = 1'b0;
        check("s_end_ready", 32'(s_inc_ready), 1);

        // Reset in the middle of a readout.
        repeat (25) push(int'($urandom_range(90, 120)));
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        rd_ready = 1'b1;
        n = 0;
        while (!(rd_valid && rd_bin == AW'(100)) && n < 300) begin tick(); n++; end
        rd_ready = 1'b0;
        check("mid_at100", 32'(rd_bin), 100);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rd_valid), 0);
        check("mid_rst_ready", 32'(inc_ready), 0);
        check("mid_rst_busy", 32'(busy), 1);
        tick();
        rst = 1'b0;
        clear_model();
        drops = 0;
        check("mid_rst_dropped", 32'(dropped), 0);
        repeat (NB - 1) tick();
        check("mid_sweep_not_done", 32'(inc_ready), 0);
        tick();
        check("mid_sweep_done", 32'(inc_ready), 1);
        readout("post_rst", 40, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tcspc_histogram_mem.md
Name: tcspc_histogram_mem

Overview:
Parametrised successor to the photon-arrival histogram memory. Accumulates per-bin event counts in a RAM-style array with a read-modify-write pipeline, and supports NUM_BINS bins of COUNT_W bits each. Adds a hardware clear sweep and a serial, handshaked readout stream that replaces the flat bus output. Sits between the time-to-bin quantiser (upstream) and the readout/UART packer (downstream).

Parameters:
NUM_BINS, 256, number of histogram bins; power of two, >= 4.
BIN_ADDR_W, 8, bin index width; equals log2(NUM_BINS).
COUNT_W, 16, bits per bin counter.
DROP_W, 16, width of the dropped-event counter.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
inc_valid  in  1  event strobe; one increment per cycle
inc_bin  in  BIN_ADDR_W  bin index of the event
inc_ready  out  1  high when events are accepted (ACCUM state)
clear_req  in  1  single-cycle pulse; starts a clear sweep
rd_start  in  1  single-cycle pulse; starts a readout
rd_valid  out  1  readout word valid
rd_ready  in  1  downstream accepts the readout word
rd_bin  out  BIN_ADDR_W  bin index of the current readout word
rd_data  out  COUNT_W  count of bin rd_bin
rd_last  out  1  high with the final bin (NUM_BINS-1)
busy  out  1  high in CLEAR or READOUT, or while the pipeline is not empty
dropped  out  DROP_W  events presented while inc_ready was low; saturates at all-ones

Behaviour:
- Clock and reset: single clock domain. The rst assertion takes effect immediately (async); release is synchronous to clk.
- Reset values: inc_ready=0, rd_valid=0, rd_last=0, rd_bin=0, rd_data=0, busy=1, dropped=0. The FSM enters CLEAR. Array contents are not reset directly; the CLEAR sweep zeroes them.
- FSM states: CLEAR, ACCUM, DRAIN, READOUT.
  - CLEAR: writes 0 to bins 0..NUM_BINS-1, one bin per cycle. Takes NUM_BINS cycles, then goes to ACCUM. dropped is not cleared by the sweep.
  - ACCUM: inc_ready=1.
    - clear_req -> DRAIN, then CLEAR.
    - rd_start -> DRAIN, then READOUT.
    - If both are asserted in the same cycle, clear_req wins and rd_start is ignored.
  - DRAIN: inc_ready=0. Waits until the 2-stage increment pipeline is empty, then goes to the pending target. Lasts at most 2 cycles.
  - READOUT: streams bins 0..NUM_BINS-1 in order.
    - A word transfers when rd_valid && rd_ready.
    - rd_valid, rd_bin and rd_data hold stable while rd_ready=0.
    - rd_last=1 on bin NUM_BINS-1; after that transfer -> ACCUM.
    - Readout does not modify counts.
    - clear_req during READOUT aborts the stream: rd_valid drops the next cycle -> CLEAR.
    - rd_start outside ACCUM is ignored.
- Increment pipeline:
  - Stage 1 registers the accepted bin and reads the array.
  - Stage 2 writes count+1.
  - Latency from acceptance to the updated value being stored: 2 cycles.
  - Back-to-back or one-apart events to the same bin forward the in-flight value. N events to bin k always yield exactly N, at full rate of 1 event per cycle.
- Arithmetic: the count wraps modulo 2^COUNT_W (see the optional feature for saturation).
- Drops: inc_valid && !inc_ready increments dropped, which saturates at 2^DROP_W-1. dropped resets only on rst.
- Reset mid-operation: any in-flight write is discarded. A readout in progress is abandoned (rd_valid=0) and the FSM restarts in CLEAR.

Optional Feature:
HIST_SATURATE_EN
- Defined: a bin at 2^COUNT_W-1 stays there on further increments. The forwarding path uses the same saturated value.
- Undefined: bins wrap to 0 after 2^COUNT_W-1 (default).

Test Plan:
- Release rst, wait NUM_BINS+2 cycles -> inc_ready=1, busy=0. A full readout returns rd_data=0 for all 256 bins, with rd_last only on bin 255.
- 10 consecutive-cycle events to bin 5, plus events to bins 5,6,5 on alternating cycles -> readout gives bin5=12, bin6=1, all others 0.
- Readout with rd_ready toggled 1-0-0-1 pseudo-randomly -> rd_bin, rd_data stable while stalled. Exactly 256 transfers, in order 0..255, and the FSM returns to ACCUM.
- 20 events presented during a CLEAR sweep, then 3 during READOUT -> dropped=23 and no bin changed. A subsequent clear_req followed by readout gives all zeros, and dropped is still 23.
- COUNT_W=4, 17 events to bin 0 -> readout gives 1 without HIST_SATURATE_EN, or 15 with it defined.
- Assert rst for 1 cycle midway through a readout (bin 100) -> rd_valid=0 immediately. CLEAR runs for 256 cycles, then all bins read 0.
